riscv_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of RISCV_Decoder; supplies the 32-bit instr word that the decoder splits into format/op/funct/rd/rs1/rs2/imm.
- Holds the fetch PC and issues in-order requests to instruction memory over a req/gnt + rvalid protocol.
- Buffers returned words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

---
 rtl/riscv_fetch_unit.sv | 120 ++++++++++++
 tb/tb_riscv_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_unit
// Brief    : In-order instruction fetch with credit-limited prefetch FIFO and
//            redirect flush, feeding the decoder over valid/ready.
// Revision : 1.0
// ============================================================================
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_SUM_W = c_CNT_W + 1;

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_q_pc  [FIFO_DEPTH];
    logic [31:0]        r_q_ins [FIFO_DEPTH];

    logic               w_credit;
    logic               w_req;
    logic               w_grant;
    logic               w_rsp;
    logic               w_drop;
    logic               w_push;
    logic               w_valid;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_push_idx;
    logic [31:0]        w_redir_pc;

    // Credits count both buffered and in-flight words so a push can never overflow.
    assign w_credit   = (c_SUM_W'(r_count) + c_SUM_W'(r_outstanding)) < c_SUM_W'(FIFO_DEPTH);
    assign w_req      = !rst_i && !redirect_i && w_credit;
    assign w_grant    = w_req && imem_gnt_i;
    assign w_rsp      = imem_rvalid_i && (r_outstanding != '0);
    assign w_drop     = (r_discard != '0);
    assign w_push     = w_rsp && !w_drop && !redirect_i;
    assign w_valid    = !rst_i && !redirect_i && (r_count != '0);
    assign w_pop      = w_valid && instr_ready_i;
    assign w_push_idx = r_count - c_CNT_W'(w_pop);
    assign w_redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
        end else begin
            assert (!(imem_rvalid_i && (r_outstanding == '0)));
            r_outstanding <= r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(w_rsp);
            if (redirect_i) begin
                // Every response still in flight after this cycle belongs to the old stream.
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_discard  <= r_outstanding - c_CNT_W'(w_rsp);
                r_count    <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_rsp && w_drop) begin
                    r_discard <= r_discard - c_CNT_W'(1);
                end
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

    // Shift FIFO with slot 0 as the registered head; a slot is left untouched
    // when nothing moves into it, so the head holds its last value once drained.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_pc[i]  <= '0;
                r_q_ins[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_push && (w_push_idx == c_CNT_W'(i))) begin
                    r_q_pc[i]  <= r_resp_pc;
                    r_q_ins[i] <= imem_rdata_i;
                end else if (w_pop && (c_CNT_W'(i + 1) < r_count)) begin
                    r_q_pc[i]  <= r_q_pc[(i + 1) % FIFO_DEPTH];
                    r_q_ins[i] <= r_q_ins[(i + 1) % FIFO_DEPTH];
                end
            end
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = rst_i ? RESET_PC : r_fetch_pc;
    assign instr_valid_o = w_valid;
    assign instr_o       = rst_i ? 32'h0 : r_q_ins[0];
    assign pc_o          = rst_i ? 32'h0 : r_q_pc[0];

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_fetch_unit
// Brief    : Randomized and directed bench for riscv_fetch_unit against a
//            request/epoch-based reference model and an in-order memory.
// Revision : 1.0
// ============================================================================
module tb_riscv_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam int          c_DEPTH    = 2;

    logic        clk;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    riscv_fetch_unit #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int due; } rsp_t;
    typedef struct { logic [31:0] addr; int ep; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    rsp_t        pend[$];
    logic [31:0] granted[$];
    fl_t         fl[$];
    ent_t        mq[$];
    logic [31:0] m_fpc;
    int          epoch;
    int          cyc;
    int          n_vec;
    int          n_err;

    logic        s_rst, s_redir, s_ready, s_gnt, m_fast, m_hold;
    logic [31:0] s_rpc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic        e_valid;
        fl_t         f;
        @(posedge clk);
        #1;
        rv = 1'b0;
        rd = $urandom;
        if (!m_hold && pend.size() > 0 && pend[0].due <= cyc &&
            (m_fast || ($urandom_range(0, 2) != 0))) begin
            rv = 1'b1;
            rd = pend[0].data;
        end
        rst_i         = s_rst;
        redirect_i    = s_redir;
        redirect_pc_i = s_rpc;
        instr_ready_i = s_ready;
        imem_gnt_i    = s_gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        #4;
        if (s_rst) begin
            chk("rst_req", 32'(imem_req_o), 32'd0);
            chk("rst_valid", 32'(instr_valid_o), 32'd0);
            chk("rst_addr", imem_addr_o, c_RESET_PC);
            chk("rst_instr", instr_o, 32'd0);
            chk("rst_pc", pc_o, 32'd0);
            mq.delete();
            fl.delete();
            m_fpc = c_RESET_PC;
        end else begin
            e_req   = !s_redir && ((mq.size() + fl.size()) < c_DEPTH);
            e_valid = !s_redir && (mq.size() > 0);
            chk("req", 32'(imem_req_o), 32'(e_req));
            chk("addr", imem_addr_o, m_fpc);
            chk("valid", 32'(instr_valid_o), 32'(e_valid));
            if (e_valid) begin
                chk("pc", pc_o, mq[0].pc);
                chk("instr", instr_o, mq[0].ins);
            end
            if (e_valid && s_ready) mq.pop_front();
            if (rv && fl.size() > 0) begin
                f = fl.pop_front();
                if (f.ep == epoch && !s_redir) mq.push_back('{f.addr, rd});
            end
            if (e_req && s_gnt) begin
                fl.push_back('{m_fpc, epoch});
                m_fpc = m_fpc + 32'd4;
            end
            if (s_redir) begin
                mq.delete();
                epoch++;
                m_fpc = s_rpc & 32'hFFFF_FFFC;
            end
        end
        if (rv) pend.pop_front();
        if (imem_req_o && imem_gnt_i) begin
            pend.push_back('{memfn(imem_addr_o),
                             cyc + 1 + (m_fast ? 0 : int'($urandom_range(0, 3)))});
            granted.push_back(imem_addr_o);
        end
        if (s_rst) pend.delete();
        cyc++;
    endtask

    initial begin
        int found;
        int seen;
        clk = 1'b0; rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        instr_ready_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        n_vec = 0; n_err = 0; cyc = 0; epoch = 0; m_fpc = c_RESET_PC;
        s_rst = 1'b1; s_redir = 1'b0; s_rpc = '0; s_ready = 1'b1; s_gnt = 1'b1;
        m_fast = 1'b1; m_hold = 1'b0;

        // Reset release with zero-wait memory and an always-ready decoder
        repeat (3) step();
        s_rst = 1'b0;
        step();
        chk("rel_c0_req", 32'(imem_req_o), 32'd1);
        chk("rel_c0_addr", imem_addr_o, 32'h0000_0100);
        step();
        chk("rel_c1_valid", 32'(instr_valid_o), 32'd0);
        step();
        chk("rel_c2_valid", 32'(instr_valid_o), 32'd1);
        chk("rel_c2_pc", pc_o, 32'h0000_0100);
        chk("rel_c2_instr", instr_o, memfn(32'h0000_0100));
        step();
        chk("rel_c3_pc", pc_o, 32'h0000_0104);
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            step();
            if (instr_valid_o) found = 1;
        end
        chk("rel_third_pc", pc_o, 32'h0000_0108);

        // Decoder stall: credits run out, nothing is lost
        s_ready = 1'b0;
        repeat (10) step();
        chk("stall_req", 32'(imem_req_o), 32'd0);
        chk("stall_valid", 32'(instr_valid_o), 32'd1);
        s_ready = 1'b1;
        repeat (12) step();

        // Redirect to 0x2003 with two responses outstanding
        m_hold = 1'b1;
        repeat (6) step();
        chk("hold_req", 32'(imem_req_o), 32'd0);
        chk("hold_valid", 32'(instr_valid_o), 32'd0);
        s_redir = 1'b1; s_rpc = 32'h0000_2003;
        step();
        chk("redir_req", 32'(imem_req_o), 32'd0);
        s_redir = 1'b0; m_hold = 1'b0;
        step();
        chk("redir_addr", imem_addr_o, 32'h0000_2000);
        seen = 0; found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            if (seen == 0 && imem_req_o) begin
                seen = 1;
                chk("redir_first_req", imem_addr_o, 32'h0000_2000);
            end
            if (instr_valid_o) found = 1;
            else step();
        end
        chk("redir_first_pc", pc_o, 32'h0000_2000);
        chk("redir_first_instr", instr_o, memfn(32'h0000_2000));

        // Redirect coinciding with rvalid and a poppable head
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (mq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) begin
                s_redir = 1'b1; s_rpc = 32'h0000_3000;
                found = 1;
            end
            step();
            s_redir = 1'b0;
        end
        chk("coinc_found", 32'(found), 32'd1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (instr_valid_o) found = 1;
        end
        chk("coinc_first_pc", pc_o, 32'h0000_3000);

        // Grant withheld for five cycles
        s_gnt = 1'b0;
        repeat (6) step();
        s_redir = 1'b1; s_rpc = 32'h0000_4000;
        step();
        s_redir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nognt_req", 32'(imem_req_o), 32'd1);
            chk("nognt_addr", imem_addr_o, 32'h0000_4000);
        end
        s_gnt = 1'b1;
        step();
        chk("gnt_addr", imem_addr_o, 32'h0000_4000);
        step();
        chk("post_gnt_addr", imem_addr_o, 32'h0000_4004);

        // Address wrap past the top of memory
        s_redir = 1'b1; s_rpc = 32'hFFFF_FFF8;
        step();
        s_redir = 1'b0;
        granted.delete();
        repeat (10) step();
        chk("wrap_cnt_ok", 32'(granted.size() >= 3), 32'd1);
        if (granted.size() >= 3) begin
            chk("wrap_a0", granted[0], 32'hFFFF_FFF8);
            chk("wrap_a1", granted[1], 32'hFFFF_FFFC);
            chk("wrap_a2", granted[2], 32'h0000_0000);
        end

        // Reset in the middle of a stream
        s_rst = 1'b1;
        step();
        chk("midrst_req", 32'(imem_req_o), 32'd0);
        chk("midrst_valid", 32'(instr_valid_o), 32'd0);
        s_rst = 1'b0;
        step();
        chk("midrst_rel_addr", imem_addr_o, c_RESET_PC);

        // Randomized traffic
        m_fast = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            s_gnt   = ($urandom_range(0, 9) < 7);
            s_ready = ($urandom_range(0, 9) < 6);
            s_redir = ($urandom_range(0, 11) == 0);
            s_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            s_rst   = ($urandom_range(0, 299) == 0);
            step();
        end
        s_rst = 1'b0; s_redir = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
